// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding ({funct7[5], funct3}) and default datapath width.
package alu_pkg;

   localparam int unsigned DefaultWidth = 32;

   typedef enum logic [3:0] {
      AluAdd  = 4'b0000,
      AluSll  = 4'b0001,
      AluSlt  = 4'b0010,
      AluSltu = 4'b0011,
      AluXor  = 4'b0100,
      AluSrl  = 4'b0101,
      AluOr   = 4'b0110,
      AluAnd  = 4'b0111,
      AluSub  = 4'b1000,
      AluSra  = 4'b1101
   } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter producing logical-left, logical-right and arithmetic-right results.
module alu_shifter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ShW   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [ShW-1:0]   shamt,
   output logic [WIDTH-1:0] sll,
   output logic [WIDTH-1:0] srl,
   output logic [WIDTH-1:0] sra
);

   assign sll = a << shamt;
   assign srl = a >> shamt;
   assign sra = $signed(a) >>> shamt;

endmodule

// File: rtl/alu_core.sv
// Single-cycle registered ALU; the result and its zero flag are captured together on valid input.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       AluOp,
   input  logic             in_valid,
   output logic [WIDTH-1:0] S,
   output logic             out_valid,
   output logic             zero
);

   localparam int unsigned ShW = $clog2(WIDTH);

   logic [WIDTH-1:0] sll, srl, sra;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] s_d, s_q;
   logic             zero_d, zero_q;
   logic             valid_q;
   alu_op_e          op;

   assign op = alu_op_e'(AluOp);

   alu_shifter #(
      .WIDTH (WIDTH),
      .ShW   (ShW)
   ) u_shifter (
      .a     (A),
      .shamt (B[ShW-1:0]),
      .sll   (sll),
      .srl   (srl),
      .sra   (sra)
   );

   always_comb begin
      result = '0;
      case (op)
         AluAdd:  result = A + B;
         AluSub:  result = A - B;
         AluSll:  result = sll;
         AluSlt:  result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         AluSltu: result = {{(WIDTH-1){1'b0}}, (A < B)};
         AluXor:  result = A ^ B;
         AluSrl:  result = srl;
         AluSra:  result = sra;
         AluOr:   result = A | B;
         AluAnd:  result = A & B;
         default: result = '0;
      endcase
   end

   // Flag derives from the next-state value so it never lags S.
   always_comb begin
      s_d    = in_valid ? result : s_q;
      zero_d = in_valid ? (result == '0) : zero_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q     <= '0;
         zero_q  <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         s_q     <= s_d;
         zero_q  <= zero_d;
         valid_q <= in_valid;
      end
   end

   assign S         = s_q;
   assign zero      = zero_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: directed vectors, back-to-back random ops, hold and reset behaviour.
module tb_alu_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] A, B;
   logic [3:0]  AluOp;
   logic        in_valid;
   logic [31:0] S;
   logic        out_valid;
   logic        zero;

   typedef struct {
      string       tag;
      logic [31:0] s;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic        mon_en = 1'b0;
   logic        exp_vld;
   logic [31:0] last_s = '0;

   alu_core #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .AluOp     (AluOp),
      .in_valid  (in_valid),
      .S         (S),
      .out_valid (out_valid),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         4'b0000: return a + b;
         4'b1000: return a + ~b + 32'd1;
         4'b0001: return a << sh;
         4'b0010: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
         4'b0011: return {31'd0, a < b};
         4'b0100: return a ^ b;
         4'b0101: return a >> sh;
         4'b1101: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         4'b0110: return a | b;
         4'b0111: return a & b;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) exp_vld <= 1'b0;
      else     exp_vld <= in_valid;
   end

   // Pops one expectation per reported result; otherwise the previous result must be held.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         last_s = '0;
      end else if (mon_en) begin
         check("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check(e.tag, S, e.s);
               check({e.tag, "_zero"}, {31'd0, zero}, {31'd0, e.s == 32'd0});
               last_s = e.s;
            end
         end else begin
            check("hold_S", S, last_s);
            check("hold_zero", {31'd0, zero}, {31'd0, last_s == 32'd0});
         end
      end
   end

   task automatic drive(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
      exp_t e;
      @(negedge clk);
      AluOp    = op;
      A        = a;
      B        = b;
      in_valid = 1'b1;
      e.tag    = tag;
      e.s      = exp;
      sb.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      A        = $urandom;
      B        = $urandom;
      AluOp    = 4'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      A        = '0;
      B        = '0;
      AluOp    = '0;
      #1;
      check("rst_S", S, 32'd0);
      check("rst_zero", {31'd0, zero}, 32'd1);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b1;
      A        = 32'd5;
      B        = 32'd3;
      @(posedge clk);
      #1;
      check("rst_clk_S", S, 32'd0);
      check("rst_clk_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      mon_en   = 1'b1;

      drive("add_5_3",    4'b0000, 32'd5,          32'd3,  32'd8);
      drive("sub_8_3",    4'b1000, 32'd8,          32'd3,  32'd5);
      drive("sll_4_2",    4'b0001, 32'd4,          32'd2,  32'd16);
      drive("slt_m5_3",   4'b0010, 32'hFFFF_FFFB,  32'd3,  32'd1);
      drive("sltu_m5_3",  4'b0011, 32'hFFFF_FFFB,  32'd3,  32'd0);
      drive("slt_5_3",    4'b0010, 32'd5,          32'd3,  32'd0);
      drive("xor_5_3",    4'b0100, 32'd5,          32'd3,  32'd6);
      drive("or_5_3",     4'b0110, 32'd5,          32'd3,  32'd7);
      drive("and_5_3",    4'b0111, 32'd5,          32'd3,  32'd1);
      drive("srl_8_2",    4'b0101, 32'd8,          32'd2,  32'd2);
      drive("sra_m8_2",   4'b1101, 32'hFFFF_FFF8,  32'd2,  32'hFFFF_FFFE);
      drive("srl_m8_2",   4'b0101, 32'hFFFF_FFF8,  32'd2,  32'h3FFF_FFFE);
      drive("add_wrap",   4'b0000, 32'hFFFF_FFFF,  32'd1,  32'd0);
      drive("sub_0_1",    4'b1000, 32'd0,          32'd1,  32'hFFFF_FFFF);
      drive("sll_b25",    4'b0001, 32'd1,          32'h25, 32'd32);
      drive("sra_sh0",    4'b1101, 32'h8000_0000,  32'h20, 32'h8000_0000);
      drive("slt_min",    4'b0010, 32'h8000_0000,  32'h7FFF_FFFF, 32'd1);
      idle();
      idle();
      drive("op_1111",    4'b1111, 32'd5,          32'd3,  32'd0);
      drive("op_1001",    4'b1001, 32'hDEAD_BEEF,  32'd1,  32'd0);
      drive("or_nz",      4'b0110, 32'h00F0_0000,  32'd0,  32'h00F0_0000);
      idle();

      for (int i = 0; i < 24; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         drive($sformatf("rand%0d_op%0h", i, op), op, a, b, ref_alu(op, a, b));
      end
      idle();

      // Reset lands between edges while a result is being presented.
      drive("pre_rst", 4'b0000, 32'd7, 32'd9, 32'd16);
      @(posedge clk);
      #2;
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      check("midrst_S", S, 32'd0);
      check("midrst_zero", {31'd0, zero}, 32'd1);
      check("midrst_valid", {31'd0, out_valid}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rsthold_S", S, 32'd0);
      check("rsthold_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      idle();
      idle();
      drive("post_rst", 4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
      idle();
      idle();
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
